// File: rtl/dm_arbiter_if.sv
// Bus bundle between the two data-memory requesters, the arbiter and the DM.
// master = requesters plus DM model side, slave = arbiter side.
interface dm_arbiter_if #(
    parameter int ADDR_W = 14
);
    logic              cpu_req;
    logic              cpu_we;
    logic [1:0]        cpu_width;
    logic              cpu_sign;
    logic [31:0]       cpu_addr;
    logic [31:0]       cpu_wdata;
    logic [31:0]       cpu_rdata;
    logic              cpu_ack;
    logic              cpu_stall;
    logic              ext_req;
    logic              ext_we;
    logic [1:0]        ext_width;
    logic              ext_sign;
    logic [31:0]       ext_addr;
    logic [31:0]       ext_wdata;
    logic [31:0]       ext_rdata;
    logic              ext_ack;
    logic              dm_we;
    logic [1:0]        dm_width;
    logic              dm_sign;
    logic [ADDR_W-1:0] dm_addr;
    logic [31:0]       dm_wdata;
    logic [31:0]       dm_rdata;

    modport master (
        output cpu_req, cpu_we, cpu_width, cpu_sign, cpu_addr, cpu_wdata,
        output ext_req, ext_we, ext_width, ext_sign, ext_addr, ext_wdata,
        output dm_rdata,
        input  cpu_rdata, cpu_ack, cpu_stall, ext_rdata, ext_ack,
        input  dm_we, dm_width, dm_sign, dm_addr, dm_wdata
    );

    modport slave (
        input  cpu_req, cpu_we, cpu_width, cpu_sign, cpu_addr, cpu_wdata,
        input  ext_req, ext_we, ext_width, ext_sign, ext_addr, ext_wdata,
        input  dm_rdata,
        output cpu_rdata, cpu_ack, cpu_stall, ext_rdata, ext_ack,
        output dm_we, dm_width, dm_sign, dm_addr, dm_wdata
    );
endinterface

// File: rtl/dm_arbiter.sv
// Round-robin arbiter/sequencer for the single-port data memory:
// CPU M-stage (port 0) vs external bridge (port 1), fixed read latency.
module dm_arbiter #(
    parameter int ADDR_W  = 14,
    parameter int LATENCY = 1
) (
    input  logic         clk,
    input  logic         reset,
    dm_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_t;

    localparam logic [3:0] LAT = 4'(LATENCY);

    state_t            r_state;
    logic [3:0]        r_cnt;
    logic              r_gnt;
    logic              r_last;
    logic              r_dm_we;
    logic [1:0]        r_width;
    logic              r_sign;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic [31:0]       r_cpu_rdata;
    logic [31:0]       r_ext_rdata;
    logic              r_cpu_ack;
    logic              r_ext_ack;

    logic              w_any;
    logic              w_pick_ext;

    // r_last=1 means ext won last time, so a tie goes to the CPU
    assign w_any      = bus.cpu_req | bus.ext_req;
    assign w_pick_ext = bus.ext_req & (~bus.cpu_req | ~r_last);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= 4'd0;
            r_gnt       <= 1'b0;
            r_last      <= 1'b1;
            r_dm_we     <= 1'b0;
            r_width     <= 2'd0;
            r_sign      <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= 32'd0;
            r_cpu_rdata <= 32'd0;
            r_ext_rdata <= 32'd0;
            r_cpu_ack   <= 1'b0;
            r_ext_ack   <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_gnt   <= w_pick_ext;
                        r_last  <= w_pick_ext;
                        r_state <= S_ISSUE;
                        if (w_pick_ext) begin
                            r_dm_we <= bus.ext_we;
                            r_width <= bus.ext_width;
                            r_sign  <= bus.ext_sign;
                            r_addr  <= bus.ext_addr[ADDR_W-1:0];
                            r_wdata <= bus.ext_wdata;
                        end else begin
                            r_dm_we <= bus.cpu_we;
                            r_width <= bus.cpu_width;
                            r_sign  <= bus.cpu_sign;
                            r_addr  <= bus.cpu_addr[ADDR_W-1:0];
                            r_wdata <= bus.cpu_wdata;
                        end
                    end
                end
                S_ISSUE: begin
                    r_dm_we <= 1'b0;
                    r_cnt   <= LAT;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (r_cnt == 4'd1) begin
                        if (r_gnt) r_ext_rdata <= bus.dm_rdata;
                        else       r_cpu_rdata <= bus.dm_rdata;
                        r_cpu_ack <= ~r_gnt;
                        r_ext_ack <= r_gnt;
                        r_state   <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_RESP: begin
                    r_cpu_ack <= 1'b0;
                    r_ext_ack <= 1'b0;
                    r_state   <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.dm_we     = r_dm_we;
    assign bus.dm_width  = r_width;
    assign bus.dm_sign   = r_sign;
    assign bus.dm_addr   = r_addr;
    assign bus.dm_wdata  = r_wdata;
    assign bus.cpu_rdata = r_cpu_rdata;
    assign bus.ext_rdata = r_ext_rdata;
    assign bus.cpu_ack   = r_cpu_ack;
    assign bus.ext_ack   = r_ext_ack;
    assign bus.cpu_stall = bus.cpu_req & ~r_cpu_ack;
endmodule

// File: doc/dm_arbiter.md
Name: dm_arbiter

Overview:
- Two-requester arbiter and sequencer for the single-port data memory behind the M-stage.
- Requesters: port 0 is the CPU M-stage load/store; port 1 is the external bridge/debug port.
- Grants round-robin, latches the winning request, drives the DM for a fixed read latency, then returns registered read data with a one-cycle ack.
- Generates the CPU stall that freezes the pipeline while a CPU access is outstanding.

Parameters:
ADDR_W, 14, DM byte-address width; addresses are truncated to ADDR_W bits before reaching the DM.
LATENCY, 1, rising edges from DM address presentation to valid dm_rdata; legal range 1..15.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-low reset.
cpu_req  input  1  CPU access request; held until cpu_ack.
cpu_we  input  1  1=store, 0=load.
cpu_width  input  2  0=byte, 1=half, 2=word.
cpu_sign  input  1  load sign-extend enable.
cpu_addr  input  32  byte address.
cpu_wdata  input  32  store data.
cpu_rdata  output  32  registered load data; valid while cpu_ack=1.
cpu_ack  output  1  one-cycle completion pulse.
cpu_stall  output  1  equals cpu_req AND NOT cpu_ack (combinational).
ext_req  input  1  external port request.
ext_we  input  1  as cpu_we.
ext_width  input  2  as cpu_width.
ext_sign  input  1  as cpu_sign.
ext_addr  input  32  as cpu_addr.
ext_wdata  input  32  as cpu_wdata.
ext_rdata  output  32  as cpu_rdata.
ext_ack  output  1  as cpu_ack.
dm_we  output  1  DM write enable.
dm_width  output  2  DM access width.
dm_sign  output  1  DM load sign.
dm_addr  output  ADDR_W  DM byte address.
dm_wdata  output  32  DM write data.
dm_rdata  input  32  DM read data.

Behaviour:
- Reset (reset=0, asynchronous):
  - State returns to IDLE.
  - All outputs go to 0: dm_we, cpu_ack, ext_ack, cpu_rdata, ext_rdata, and the latched dm_* fields.
  - last_grant is set to ext, so the first tie goes to the CPU.
  - dm_we drops immediately, so an in-flight write is never re-issued after reset.
- IDLE:
  - With neither request asserted, stay in IDLE.
  - With exactly one request, grant it.
  - With both requests, grant the port that is not last_grant.
  - On grant, latch we/width/sign/addr[ADDR_W-1:0]/wdata and the grant id, update last_grant, and move to ISSUE.
- ISSUE (1 cycle):
  - dm_* outputs carry the latched fields.
  - dm_we equals the latched we in this cycle only.
  - Load counter with LATENCY; move to WAIT.
- WAIT (LATENCY cycles):
  - dm_addr, dm_width and dm_sign are held stable; dm_we=0.
  - Counter decrements each cycle.
  - On the edge ending the last WAIT cycle, capture dm_rdata into the granted port's rdata register; move to RESP.
  - For writes, the capture still occurs; its value is don't-care.
- RESP (1 cycle):
  - The granted port's ack is 1; the other port's ack is 0.
  - rdata is valid in this cycle and holds its value until overwritten by that port's next completion.
  - Next state is IDLE; no grant is made in RESP.
- Latency: a request sampled in IDLE at cycle T gets its ack in cycle T+2+LATENCY.
  - Minimum spacing between grants is 3+LATENCY cycles.
- A requester dropping req mid-transaction does not abort it: the access completes and ack still pulses.
- The DM performs no further access until the next ISSUE.
- Starvation: with both requests held continuously, grants strictly alternate cpu, ext, cpu, ...
- Misaligned addresses and width/address legality are not checked; fields pass through unchanged.
- Address truncation: dm_addr = addr mod 2^ADDR_W. With the default ADDR_W=14, addr 0x00003FFC maps to 0x3FFC and 0x00004000 maps to 0x0000.
- dm_* fields other than dm_we hold their last latched value while IDLE/RESP.

Test Plan:
- Reset, then CPU load alone (LATENCY=1): cpu_req at T, addr 0x10, dm_rdata=0xDEADBEEF -> dm_we=0 throughout, cpu_ack=1 and cpu_rdata=0xDEADBEEF at T+3, cpu_stall=1 for T..T+2.
- CPU store alone: addr 0x20, wdata 0x12345678, width 2 -> dm_we=1 for exactly one cycle (T+1) with dm_addr=0x20 and dm_wdata=0x12345678; cpu_ack at T+3.
- Both requests held for 4 transactions -> grant order cpu, ext, cpu, ext; each ack only on its owner; ext_ack never coincides with cpu_ack.
- Address wrap: ext load addr 0x00004004 -> dm_addr=0x0004.
- LATENCY=3, CPU load -> dm_addr stable for cycles T+1..T+4, cpu_ack at T+5.
- Reset asserted during the ISSUE cycle of a store -> dm_we falls without waiting for clk, no ack pulses, state IDLE, and after release the store is not re-executed unless re-requested.
